// File: rtl/nanorv32_axi_pkg.sv
// nanorv32_axi_pkg
// Shared definitions for the nanorv32 AXI4-Lite adapter: response codes,
// FSM state encoding, protection-bit layout and small helpers.
package nanorv32_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AxPROT[2] distinguishes instruction from data accesses.
  localparam int unsigned PROT_INSTR = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4
  } state_t;

  // AXI4-Lite has no exclusive access, so anything but OKAY is an error
  // from the core's point of view (EXOKAY included).
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

  function automatic logic [2:0] prot_for(input logic instr);
    logic [2:0] p;
    p = 3'b000;
    p[PROT_INSTR] = instr;
    return p;
  endfunction

endpackage

// File: rtl/nanorv32_axil_adapter.sv
// nanorv32_axil_adapter
// Bridges the nanorv32 native memory port (mem_valid/mem_ready) to a
// single-outstanding AXI4-Lite master. One request is in flight at a time;
// non-OKAY responses are reported on mem_err together with mem_ready.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   mem_valid/mem_ready   core request / one-cycle completion pulse
//   mem_instr             request is an instruction fetch (drives AxPROT[2])
//   mem_addr/wdata/wstrb  request payload, wstrb == 0 means read
//   mem_rdata/mem_err     read data and error flag, valid with mem_ready
//   m_aw*, m_w*, m_b*     AXI4-Lite write address / data / response
//   m_ar*, m_r*           AXI4-Lite read address / data
//
// States
//   state    | meaning
//   ST_IDLE  | waiting for a new core request
//   ST_WADDR | AW and/or W still waiting for their handshake
//   ST_WRESP | both write beats sent, waiting for B
//   ST_RADDR | AR waiting for its handshake
//   ST_RDATA | waiting for R
module nanorv32_axil_adapter
  import nanorv32_axi_pkg::*;
#(
  parameter bit          USE_PROT  = 1'b1,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        mem_valid,
  input  logic        mem_instr,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_err,

  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,

  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,

  input  logic        m_bvalid,
  output logic        m_bready,
  input  logic [1:0]  m_bresp,

  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,

  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp
);

  state_t      state_q, state_d;

  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        arvalid_q, arvalid_d;
  logic        bready_q, bready_d;
  logic        rready_q, rready_d;
  logic        mem_ready_q, mem_ready_d;
  logic        mem_err_q, mem_err_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  prot_q;

  logic        accept;
  logic        is_write;
  logic        aw_pending;
  logic        w_pending;

  // mem_ready is still high in the cycle after completion while the core
  // holds its old request; the guard keeps that request from re-issuing.
  assign accept   = (state_q == ST_IDLE) && mem_valid && !mem_ready_q;
  assign is_write = |mem_wstrb;

  // AW and W retire independently; a channel stays pending until its own
  // handshake, whatever the other channel does.
  assign aw_pending = awvalid_q && !m_awready;
  assign w_pending  = wvalid_q && !m_wready;

  // State register plus the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_err_q   <= 1'b0;
      mem_rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      mem_ready_q <= mem_ready_d;
      mem_err_q   <= mem_err_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Request payload is captured once on accept so the AXI side never
  // depends on the core keeping its bus stable.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      wstrb_q <= mem_wstrb;
      prot_q  <= prot_for(USE_PROT && mem_instr);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = is_write ? ST_WADDR : ST_RADDR;
        end
      end
      ST_WADDR: begin
        if (!aw_pending && !w_pending) begin
          state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (m_bvalid) begin
          state_d = ST_IDLE;
        end
      end
      ST_RADDR: begin
        if (m_arready) begin
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (m_rvalid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs; everything here lands one
  // cycle later through the state register process.
  always_comb begin
    awvalid_d   = 1'b0;
    wvalid_d    = 1'b0;
    arvalid_d   = 1'b0;
    bready_d    = 1'b0;
    rready_d    = 1'b0;
    mem_ready_d = 1'b0;
    mem_err_d   = 1'b0;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WADDR: begin
        awvalid_d = aw_pending;
        wvalid_d  = w_pending;
        bready_d  = !aw_pending && !w_pending;
      end
      ST_WRESP: begin
        if (m_bvalid) begin
          mem_ready_d = 1'b1;
          mem_err_d   = resp_is_err(m_bresp);
        end else begin
          bready_d = 1'b1;
        end
      end
      ST_RADDR: begin
        arvalid_d = !m_arready;
        rready_d  = m_arready;
      end
      ST_RDATA: begin
        if (m_rvalid) begin
          mem_ready_d = 1'b1;
          mem_err_d   = resp_is_err(m_rresp);
          mem_rdata_d = resp_is_err(m_rresp) ? ERR_RDATA : m_rdata;
        end else begin
          rready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign mem_ready = mem_ready_q;
  assign mem_err   = mem_err_q;
  assign mem_rdata = mem_rdata_q;

  assign m_awvalid = awvalid_q;
  assign m_awaddr  = addr_q;
  assign m_awprot  = prot_q;

  assign m_wvalid  = wvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;

  assign m_bready  = bready_q;

  assign m_arvalid = arvalid_q;
  assign m_araddr  = addr_q;
  assign m_arprot  = prot_q;

  assign m_rready  = rready_q;

endmodule

// File: tb/tb_nanorv32_axil_adapter.sv
// tb_nanorv32_axil_adapter
// Drives the adapter from a core-side request task against a behavioural
// AXI4-Lite slave with random channel delays. Expected read data comes from
// a word-level reference memory updated from the core's own requests.
module tb_nanorv32_axil_adapter;
  import nanorv32_axi_pkg::*;

  localparam logic [31:0] ERR_RDATA_EXP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0, mem_instr = 1'b0, mem_ready;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_err;
  logic        m_awvalid, m_awready = 1'b0;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awprot;
  logic        m_wvalid, m_wready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid = 1'b0, m_bready;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_arvalid, m_arready = 1'b0;
  logic [31:0] m_araddr;
  logic [2:0]  m_arprot;
  logic        m_rvalid = 1'b0, m_rready;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = 2'b00;

  nanorv32_axil_adapter #(.USE_PROT(1'b1), .ERR_RDATA(ERR_RDATA_EXP)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // slave configuration: fixed delay (>=0) or random 0..max_dly (-1)
  int          max_dly = 0;
  int          fix_aw = 0, fix_w = 0, fix_ar = 0, fix_b = 0, fix_r = 0;
  logic [1:0]  bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;
  bit          rdata_force_en = 1'b0;
  logic [31:0] rdata_force = '0;

  // slave state and observations
  logic [31:0] slv_mem [int unsigned];
  logic [31:0] aw_q[$], wd_q[$], ar_q[$];
  logic [3:0]  ws_q[$];
  bit          aw_arm = 0, w_arm = 0, ar_arm = 0, b_arm = 0, r_arm = 0;
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
  logic [3:0]  last_wstrb = '0;
  logic [2:0]  last_awprot = '0, last_arprot = '0;
  logic [31:0] s_a, s_d;
  logic [3:0]  s_s;

  // protocol monitor
  bit          mon_en = 1'b1;
  int          viol = 0;
  logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0, p_ready = 0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
  logic [3:0]  p_wstrb = '0;
  logic [2:0]  p_awprot = '0, p_arprot = '0;

  // reference model
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] last_read = '0;
  int          exp_ar = 0, exp_aw = 0;

  function automatic logic [31:0] init_word(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]} ^ 32'hA5C3_0F1E;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nd, input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    int unsigned k;
    k = int'(addr >> 2);
    return ref_mem.exists(k) ? ref_mem[k] : init_word(addr);
  endfunction

  function automatic int pick(input int f);
    return (f >= 0) ? f : int'($urandom_range(max_dly, 0));
  endfunction

  // Everything here happens away from the active edge: readies/valids set
  // at a falling edge hold through the next rising edge, so a handshake is
  // recorded at the moment the slave completes it.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (p_awv && !p_awr && (m_awvalid !== 1'b1 || m_awaddr !== p_awaddr || m_awprot !== p_awprot)) viol++;
      if (p_wv && !p_wr && (m_wvalid !== 1'b1 || m_wdata !== p_wdata || m_wstrb !== p_wstrb)) viol++;
      if (p_arv && !p_arr && (m_arvalid !== 1'b1 || m_araddr !== p_araddr || m_arprot !== p_arprot)) viol++;
      if (mem_ready === 1'b1 && p_ready === 1'b1) viol++;
      if (mem_err === 1'b1 && mem_ready !== 1'b1) viol++;
    end
    if (reset) begin
      m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
      aw_arm = 0; w_arm = 0; ar_arm = 0; b_arm = 0; r_arm = 0;
      aw_q.delete(); wd_q.delete(); ws_q.delete(); ar_q.delete();
    end else begin
      if (m_awready) m_awready = 0;
      else if (m_awvalid === 1'b1) begin
        if (!aw_arm) begin aw_arm = 1; aw_wait = pick(fix_aw); end
        if (aw_wait == 0) begin
          m_awready = 1; aw_arm = 0; n_aw++;
          aw_q.push_back(m_awaddr); last_awaddr = m_awaddr; last_awprot = m_awprot;
        end else aw_wait--;
      end
      if (m_wready) m_wready = 0;
      else if (m_wvalid === 1'b1) begin
        if (!w_arm) begin w_arm = 1; w_wait = pick(fix_w); end
        if (w_wait == 0) begin
          m_wready = 1; w_arm = 0; n_w++;
          wd_q.push_back(m_wdata); ws_q.push_back(m_wstrb);
          last_wdata = m_wdata; last_wstrb = m_wstrb;
        end else w_wait--;
      end
      if (m_arready) m_arready = 0;
      else if (m_arvalid === 1'b1) begin
        if (!ar_arm) begin ar_arm = 1; ar_wait = pick(fix_ar); end
        if (ar_wait == 0) begin
          m_arready = 1; ar_arm = 0; n_ar++;
          ar_q.push_back(m_araddr); last_araddr = m_araddr; last_arprot = m_arprot;
        end else ar_wait--;
      end
      if (m_bvalid) begin m_bvalid = 0; m_bresp = 0; end
      else if (m_bready === 1'b1 && aw_q.size() > 0 && wd_q.size() > 0) begin
        if (!b_arm) begin b_arm = 1; b_wait = pick(fix_b); end
        if (b_wait == 0) begin
          b_arm = 0; m_bvalid = 1; m_bresp = bresp_cfg; n_b++;
          s_a = aw_q.pop_front(); s_d = wd_q.pop_front(); s_s = ws_q.pop_front();
          if (bresp_cfg == RESP_OKAY)
            slv_mem[int'(s_a >> 2)] = merge(slv_mem.exists(int'(s_a >> 2)) ? slv_mem[int'(s_a >> 2)] : init_word(s_a), s_d, s_s);
        end else b_wait--;
      end
      if (m_rvalid) begin m_rvalid = 0; m_rresp = 0; end
      else if (m_rready === 1'b1 && ar_q.size() > 0) begin
        if (!r_arm) begin r_arm = 1; r_wait = pick(fix_r); end
        if (r_wait == 0) begin
          r_arm = 0; m_rvalid = 1; m_rresp = rresp_cfg; n_r++;
          s_a = ar_q.pop_front();
          if (rdata_force_en) m_rdata = rdata_force;
          else m_rdata = slv_mem.exists(int'(s_a >> 2)) ? slv_mem[int'(s_a >> 2)] : init_word(s_a);
        end else r_wait--;
      end
    end
    p_awv = m_awvalid; p_awr = m_awready; p_awaddr = m_awaddr; p_awprot = m_awprot;
    p_wv = m_wvalid; p_wr = m_wready; p_wdata = m_wdata; p_wstrb = m_wstrb;
    p_arv = m_arvalid; p_arr = m_arready; p_araddr = m_araddr; p_arprot = m_arprot;
    p_ready = mem_ready;
  end

  // Core side: present a request at a falling edge, hold it until mem_ready,
  // and keep it on the bus through the ready cycle as the real core does.
  task automatic do_req(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output logic [31:0] rdata, output logic err,
                        output int lat);
    @(negedge clk);
    mem_valid = 1; mem_instr = instr; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    lat = 0;
    do begin @(negedge clk); lat++; end while (mem_ready !== 1'b1 && lat < 300);
    n_vec++;
    if (mem_ready !== 1'b1) begin
      n_err++; $display("FAIL req_timeout: addr %h got no mem_ready within %0d cycles", addr, lat);
    end
    rdata = mem_rdata; err = mem_err;
    if (wstrb == 4'b0000) exp_ar++; else exp_aw++;
  endtask

  task automatic core_idle();
    @(negedge clk);
    mem_valid = 0; mem_wstrb = 0; mem_instr = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL rst_mem_ready: got %b expected 0", mem_ready); end
    n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL rst_mem_err: got %b expected 0", mem_err); end
    n_vec++; if (mem_rdata !== 32'h0) begin n_err++; $display("FAIL rst_mem_rdata: got %h expected 0", mem_rdata); end
    n_vec++; if ({m_awvalid, m_wvalid, m_arvalid} !== 3'b000) begin n_err++; $display("FAIL rst_valids: got %b expected 000", {m_awvalid, m_wvalid, m_arvalid}); end
    n_vec++; if ({m_bready, m_rready} !== 2'b00) begin n_err++; $display("FAIL rst_readies: got %b expected 00", {m_bready, m_rready}); end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_read_basic();
    logic [31:0] rd; logic er; int lat;
    fix_aw = 0; fix_w = 0; fix_ar = 0; fix_b = 0; fix_r = 0;
    slv_mem[32'h100 >> 2] = 32'hCAFE_BABE;
    ref_mem[32'h100 >> 2] = 32'hCAFE_BABE;
    do_req(1'b0, 32'h100, 32'h0, 4'b0000, rd, er, lat);
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    n_vec++; if (rd !== 32'hCAFE_BABE) begin n_err++; $display("FAIL rd_data: got %h expected cafebabe", rd); end
    n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL rd_err: got %b expected 0", er); end
    n_vec++; if (last_araddr !== 32'h100) begin n_err++; $display("FAIL rd_araddr: got %h expected 100", last_araddr); end
    last_read = 32'hCAFE_BABE;
    core_idle();
  endtask

  task automatic test_write_wdelay();
    logic [31:0] rd; logic er; int lat; int aw0, w0, b0;
    fix_aw = 0; fix_w = 3; fix_b = 0;
    aw0 = n_aw; w0 = n_w; b0 = n_b;
    do_req(1'b0, 32'h104, 32'h1234_5678, 4'b0011, rd, er, lat);
    ref_mem[32'h104 >> 2] = merge(ref_read(32'h104), 32'h1234_5678, 4'b0011);
    n_vec++; if (lat !== 6) begin n_err++; $display("FAIL wr_latency: got %0d expected 6", lat); end
    n_vec++; if (n_aw - aw0 !== 1) begin n_err++; $display("FAIL wr_aw_count: got %0d expected 1", n_aw - aw0); end
    n_vec++; if (n_w - w0 !== 1 || n_b - b0 !== 1) begin n_err++; $display("FAIL wr_wb_count: got w=%0d b=%0d expected 1 1", n_w - w0, n_b - b0); end
    n_vec++; if (last_wstrb !== 4'b0011) begin n_err++; $display("FAIL wr_wstrb: got %b expected 0011", last_wstrb); end
    n_vec++; if (last_wdata !== 32'h1234_5678 || last_awaddr !== 32'h104) begin n_err++; $display("FAIL wr_payload: got %h@%h expected 12345678@104", last_wdata, last_awaddr); end
    n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL wr_err: got %b expected 0", er); end
    n_vec++; if (rd !== last_read) begin n_err++; $display("FAIL wr_rdata_hold: got %h expected %h", rd, last_read); end
    core_idle();
    n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL wr_ready_pulse: got %b expected 0", mem_ready); end
    fix_w = 0;
  endtask

  task automatic test_prot();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h108, 32'h0, 4'b0000, rd, er, lat);
    n_vec++; if (last_arprot !== 3'b100) begin n_err++; $display("FAIL prot_ifetch: got %b expected 100", last_arprot); end
    n_vec++; if (rd !== ref_read(32'h108)) begin n_err++; $display("FAIL prot_ifetch_data: got %h expected %h", rd, ref_read(32'h108)); end
    do_req(1'b0, 32'h10C, 32'h0, 4'b0000, rd, er, lat);
    n_vec++; if (last_arprot !== 3'b000) begin n_err++; $display("FAIL prot_data: got %b expected 000", last_arprot); end
    last_read = ref_read(32'h10C);
    do_req(1'b1, 32'h10C, 32'hA0B0_C0D0, 4'b1111, rd, er, lat);
    ref_mem[32'h10C >> 2] = 32'hA0B0_C0D0;
    n_vec++; if (last_awprot !== 3'b100) begin n_err++; $display("FAIL prot_write: got %b expected 100", last_awprot); end
    core_idle();
  endtask

  task automatic test_err_resp();
    logic [31:0] rd; logic er; int lat;
    logic [1:0] codes [3];
    codes[0] = RESP_SLVERR; codes[1] = RESP_DECERR; codes[2] = RESP_EXOKAY;
    rdata_force_en = 1; rdata_force = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      rresp_cfg = codes[i];
      do_req(1'b0, 32'h100, 32'h0, 4'b0000, rd, er, lat);
      n_vec++; if (rd !== ERR_RDATA_EXP) begin n_err++; $display("FAIL rderr_data: resp %b got %h expected %h", codes[i], rd, ERR_RDATA_EXP); end
      n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL rderr_flag: resp %b got %b expected 1", codes[i], er); end
      core_idle();
      n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL rderr_pulse: got %b expected 0", mem_err); end
    end
    last_read = ERR_RDATA_EXP;
    rdata_force_en = 0; rresp_cfg = RESP_OKAY;
    bresp_cfg = RESP_SLVERR;
    do_req(1'b0, 32'h114, 32'h5555_AAAA, 4'b1111, rd, er, lat);
    n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL wrerr_flag: got %b expected 1", er); end
    n_vec++; if (rd !== last_read) begin n_err++; $display("FAIL wrerr_rdata_hold: got %h expected %h", rd, last_read); end
    bresp_cfg = RESP_OKAY;
    do_req(1'b0, 32'h114, 32'h0, 4'b0000, rd, er, lat);
    n_vec++; if (er !== 1'b0 || rd !== ref_read(32'h114)) begin n_err++; $display("FAIL okay_after_err: got %h/%b expected %h/0", rd, er, ref_read(32'h114)); end
    last_read = ref_read(32'h114);
    core_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; int aw0;
    mon_en = 0; fix_aw = 50; fix_w = 50;
    aw0 = n_aw;
    @(negedge clk);
    mem_valid = 1; mem_instr = 0; mem_addr = 32'h110; mem_wdata = 32'hDEAD_0001; mem_wstrb = 4'b1111;
    @(negedge clk);
    n_vec++; if (m_awvalid !== 1'b1) begin n_err++; $display("FAIL rstmid_awvalid_rise: got %b expected 1", m_awvalid); end
    @(negedge clk);
    reset = 1; mem_valid = 0; mem_wstrb = 0;
    @(negedge clk);
    n_vec++; if ({m_awvalid, m_wvalid, m_arvalid} !== 3'b000) begin n_err++; $display("FAIL rstmid_valids: got %b expected 000", {m_awvalid, m_wvalid, m_arvalid}); end
    n_vec++; if ({m_bready, m_rready, mem_ready} !== 3'b000) begin n_err++; $display("FAIL rstmid_readies: got %b expected 000", {m_bready, m_rready, mem_ready}); end
    @(negedge clk);
    reset = 0;
    fix_aw = 0; fix_w = 0;
    repeat (2) @(negedge clk);
    mon_en = 1;
    do_req(1'b0, 32'h110, 32'h0, 4'b0000, rd, er, lat);
    n_vec++; if (rd !== ref_read(32'h110) || er !== 1'b0) begin n_err++; $display("FAIL rstmid_fresh_read: got %h/%b expected %h/0", rd, er, ref_read(32'h110)); end
    n_vec++; if (n_aw !== aw0) begin n_err++; $display("FAIL rstmid_no_aw: got %0d expected %0d", n_aw, aw0); end
    last_read = ref_read(32'h110);
    core_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, addr, wd, expd; logic er, instr; logic [3:0] ws; int lat; bit is_rd;
    max_dly = 5; fix_aw = -1; fix_w = -1; fix_ar = -1; fix_b = -1; fix_r = -1;
    for (int i = 0; i < 30; i++) begin
      is_rd = (i < 10) ? (i % 2 == 0) : bit'($urandom_range(1, 0));
      addr  = 32'h100 + ($urandom_range(7, 0) << 2);
      instr = is_rd ? 1'($urandom_range(1, 0)) : 1'b0;
      wd    = $urandom;
      ws    = is_rd ? 4'b0000 : 4'($urandom_range(15, 1));
      do_req(instr, addr, wd, ws, rd, er, lat);
      n_vec++; if (n_ar !== exp_ar || n_aw !== exp_aw) begin n_err++; $display("FAIL b2b_txn_count: #%0d got ar=%0d aw=%0d expected ar=%0d aw=%0d", i, n_ar, n_aw, exp_ar, exp_aw); end
      n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL b2b_err: #%0d got %b expected 0", i, er); end
      if (is_rd) begin
        expd = ref_read(addr);
        n_vec++; if (rd !== expd) begin n_err++; $display("FAIL b2b_rdata: #%0d addr %h got %h expected %h", i, addr, rd, expd); end
        n_vec++; if (last_araddr !== addr || last_arprot !== {instr, 2'b00}) begin n_err++; $display("FAIL b2b_ar: #%0d got %h/%b expected %h/%b", i, last_araddr, last_arprot, addr, {instr, 2'b00}); end
        last_read = expd;
      end else begin
        ref_mem[int'(addr >> 2)] = merge(ref_read(addr), wd, ws);
        n_vec++; if (rd !== last_read) begin n_err++; $display("FAIL b2b_rdata_hold: #%0d got %h expected %h", i, rd, last_read); end
        n_vec++; if (last_awaddr !== addr || last_wdata !== wd || last_wstrb !== ws) begin n_err++; $display("FAIL b2b_w: #%0d got %h/%h/%b expected %h/%h/%b", i, last_awaddr, last_wdata, last_wstrb, addr, wd, ws); end
      end
    end
    core_idle();
  endtask

  task automatic test_final();
    repeat (10) @(negedge clk);
    n_vec++; if (n_ar !== exp_ar || n_r !== exp_ar) begin n_err++; $display("FAIL final_reads: got ar=%0d r=%0d expected %0d", n_ar, n_r, exp_ar); end
    n_vec++; if (n_aw !== exp_aw || n_w !== exp_aw || n_b !== exp_aw) begin n_err++; $display("FAIL final_writes: got aw=%0d w=%0d b=%0d expected %0d", n_aw, n_w, n_b, exp_aw); end
    n_vec++; if (viol !== 0) begin n_err++; $display("FAIL protocol_monitor: got %0d violations expected 0", viol); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_basic();
    test_write_wdelay();
    test_prot();
    test_err_resp();
    test_reset_mid();
    test_back_to_back();
    test_final();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nanorv32_axil_adapter.md
Name: nanorv32_axil_adapter

Overview:
Bridge from the nanorv32 native memory interface (mem_valid/mem_ready handshake) to a single-outstanding AXI4-Lite master. It sits directly downstream of the core, in place of the bench memory model, and feeds an AXI4-Lite interconnect or RAM. It handles one transaction at a time and reports slave error responses back to the core side.

Parameters:
USE_PROT, 1, 1: drive AxPROT[2] from mem_instr; 0: AxPROT tied to 3'b000
ERR_RDATA, 32'h0000_0000, mem_rdata value returned when a read completes with a non-OKAY response

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
mem_valid  in  1  core request valid, held until mem_ready
mem_instr  in  1  request is an instruction fetch
mem_ready  out  1  one-cycle completion pulse to core
mem_addr  in  32  byte address
mem_wdata  in  32  write data
mem_wstrb  in  4  byte strobes; 4'b0000 means read
mem_rdata  out  32  read data, valid with mem_ready
mem_err  out  1  pulses with mem_ready when BRESP/RRESP != OKAY
m_awvalid/m_awready  out/in  1  AW handshake
m_awaddr  out  32  write address
m_awprot  out  3  write protection
m_wvalid/m_wready  out/in  1  W handshake
m_wdata  out  32  write data
m_wstrb  out  4  write strobes
m_bvalid/m_bready  in/out  1  B handshake
m_bresp  in  2  write response
m_arvalid/m_arready  out/in  1  AR handshake
m_araddr  out  32  read address
m_arprot  out  3  read protection
m_rvalid/m_rready  in/out  1  R handshake
m_rdata  in  32  read data
m_rresp  in  2  read response

Behaviour:
- Reset: mem_ready, mem_err, all m_*valid, m_bready, m_rready = 0; mem_rdata = 0; state IDLE. All outputs registered.
- States: IDLE, WADDR (AW and/or W pending), WRESP, RADDR, RDATA.
- IDLE: accept when mem_valid && !mem_ready. Latch addr, wdata, wstrb and prot (prot = {USE_PROT & mem_instr, 2'b00}).
  - |mem_wstrb: next cycle m_awvalid = m_wvalid = 1; go to WADDR.
  - Otherwise: m_arvalid = 1; go to RADDR.
- WADDR: m_awvalid drops the cycle after the AW handshake, m_wvalid the cycle after the W handshake, independently, in either order or together. When both are done, m_bready = 1; go to WRESP.
- WRESP: on m_bvalid: m_bready = 0, mem_ready = 1 for exactly one cycle, mem_err = (m_bresp != 2'b00); go to IDLE.
- RADDR: after the AR handshake, m_arvalid = 0 and m_rready = 1; go to RDATA.
- RDATA: on m_rvalid: m_rready = 0, mem_ready pulse, mem_rdata = OKAY ? m_rdata : ERR_RDATA, mem_err = (m_rresp != 2'b00); go to IDLE.
- Valid signals never drop before their handshake. AW/W/AR payloads stay stable while valid.
- Minimum latency, with a zero-wait slave (ready in the same cycle as valid, response one cycle later): mem_valid sampled at cycle 0, valids at cycle 1, response at cycle 2, mem_ready at cycle 3.
- Back-to-back: the !mem_ready guard blocks re-issuing the completed request. A new request is accepted no earlier than the cycle after the mem_ready pulse.
- mem_rdata holds its last read value across writes.
- The core does not change its request while mem_valid is high; the adapter uses latched values regardless.
- Reset mid-transaction: state returns to IDLE on the next edge and all valid/ready outputs drop. The in-flight AXI transaction is abandoned, so the interconnect must share the same reset.
- Unaligned addresses are passed through unchanged; alignment is the core's responsibility.

Decomposition:
- Shared package nanorv32_axi_pkg:
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants
  - state enum
  - PROT_INSTR bit index
- No sub-module; a single FSM file.

Test Plan:
- Read, zero-wait slave, m_rdata=32'hCAFEBABE, RRESP=OKAY at addr 0x100 -> araddr=0x100, mem_ready at cycle 3 with mem_rdata=32'hCAFEBABE, mem_err=0.
- Write 32'h12345678 with wstrb 4'b0011; AWREADY at cycle 1, WREADY delayed to cycle 4 -> AW handshake once, W stable until cycle 4, m_wstrb=4'b0011, exactly one mem_ready pulse after BVALID.
- Instruction fetch with USE_PROT=1 -> m_arprot=3'b100; data read -> 3'b000.
- Read with RRESP=SLVERR, m_rdata=32'hFFFFFFFF -> mem_rdata=ERR_RDATA (0), mem_err=1 for one cycle coincident with mem_ready.
- Reset asserted one cycle after m_awvalid rises, AWREADY still low -> next cycle all valids 0, mem_ready 0, then a fresh read completes normally.
- Ten back-to-back alternating reads/writes with random ready/valid delays (0-5 cycles) -> AXI transactions in issue order, data matches a scoreboard RAM model, no duplicate transactions.
